seq_mul_approx_u: RTL
=====================

Name: seq_mul_approx_u

Overview:
- Parametrised, multi-cycle, unsigned WIDTH x WIDTH multiplier with a run-time mode bit that selects either an exact product or a column-truncated approximate product.
- It is the sequential, handshake-driven successor to the combinational 8x8 approximate multipliers in the library.
- It is used where one low-area multiplier is time-shared and the quality/effort trade-off must be chosen per operation.
- Uses radix-2 shift-add: one partial-product row (one bit of A) per cycle.

Parameters:
- WIDTH, default 8: operand width; the product is 2*WIDTH bits. Legal range is 2..32.
- TRUNC_COLS, default 4: number of least-significant product columns dropped in approximate mode. Legal range is 0..2*WIDTH; a value of 0 makes approximate mode equal to exact mode.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- in_a  in  WIDTH  unsigned multiplicand A
- in_b  in  WIDTH  unsigned multiplier B
- in_approx  in  1  1 = truncated mode, 0 = exact mode
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_p  out  2*WIDTH  product
- out_approx  out  1  mode the result was computed in

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, out_p=0, out_approx=0.
  - Accumulator, bit counter and operand registers are cleared.
- Deassertion of reset is synchronised outside this block.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge N: latch in_a, in_b and in_approx; clear the accumulator; set the counter to 0; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each edge: if A[cnt]=1, acc += (B<<cnt) & MASK; then cnt++.
  - MASK = all ones in exact mode. In approximate mode MASK has bits [TRUNC_COLS-1:0] = 0.
  - When cnt==WIDTH-1 is processed, go to DONE at edge N+WIDTH.
  - The block always spends exactly WIDTH BUSY cycles; there is no early termination.
- DONE:
  - out_valid=1, out_p=acc, out_approx=latched mode.
  - out_p must be stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: go to IDLE at the next edge, and drop out_valid.
  - out_p and out_approx keep their last value after handoff; they are not cleared.
- Latency: the result is visible WIDTH cycles after the accept edge.
- Minimum initiation interval: WIDTH+2 cycles, with out_ready tied high.
- The input side is held off (in_ready=0) through BUSY and DONE. There is no same-cycle accept in DONE.
- Arithmetic:
  - Exact mode: out_p = A*B, computed mod 2^(2*WIDTH); it never overflows.
  - Approx mode: out_p = sum over all a_i*b_j*2^(i+j) with i+j >= TRUNC_COLS. No compensation constant is added.
  - Approx mode satisfies out_p <= exact, and exact - out_p <= sum_{c<TRUNC_COLS} (c+1)*2^c.
- in_a, in_b and in_approx are ignored when no handshake takes place. Changing them during BUSY has no effect.
- Assertion of rst_n=0 in BUSY or DONE aborts the operation and forces the reset values immediately. No result is emitted.
- A design with TRUNC_COLS > 2*WIDTH must fail elaboration.

Test Plan:
- Reset, then A=255, B=255, approx=0, WIDTH=8 -> out_valid rises 8 cycles after accept; out_p=65025; out_approx=0.
- Same operands with approx=1, TRUNC_COLS=4 -> out_p=64976 (65025-49); out_approx=1.
- A=13, B=11: approx=0 -> out_p=143; approx=1 -> out_p=112.
- Back-pressure: out_ready held 0 for 5 cycles in DONE -> out_p stays stable and in_ready stays 0. Release -> IDLE next cycle; next accept is possible at accept+10 at the earliest.
- Operand edge cases: A=0, B=255 -> 0; A=1, B=1, approx=1 -> 0; A=128, B=128, approx=1 -> 16384. Changing in_a during BUSY does not alter the result.
- rst_n pulsed low in cycle 3 of BUSY -> out_valid=0, out_p=0 and in_ready=1 asynchronously. A fresh 7x9 then returns 63.

Source files
------------

// File: rtl/seq_mul_approx_u.sv
// Time-shared radix-2 shift-add unsigned multiplier, one partial-product row per cycle.
// A per-operation mode bit selects an exact product or one with the low TRUNC_COLS columns dropped.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready=1
// BUSY   | WIDTH shift-add steps, one bit of A per cycle
// DONE   | result presented on out_p until out_ready
module seq_mul_approx_u #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TRUNC_COLS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx
);

  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [P_W-1:0] APPROX_MASK = {P_W{1'b1}} << TRUNC_COLS;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

  if (TRUNC_COLS > 2 * WIDTH) begin : g_bad_trunc
    $error("seq_mul_approx_u: TRUNC_COLS must not exceed 2*WIDTH");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_mul_approx_u: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [P_W-1:0]   b_q, b_d;
  logic             approx_q, approx_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   out_p_q, out_p_d;
  logic             out_approx_q, out_approx_d;

  logic             cnt_last;
  logic [P_W-1:0]   row_mask;
  logic [P_W-1:0]   acc_step;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign row_mask = approx_q ? APPROX_MASK : {P_W{1'b1}};
  // B is pre-shifted each cycle, so the mask applies to absolute product columns.
  assign acc_step = a_q[0] ? (acc_q + (b_q & row_mask)) : acc_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)  state_d = S_BUSY;
      S_BUSY: if (cnt_last)  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    approx_d     = approx_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_p_d      = out_p_q;
    out_approx_d = out_approx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = {{WIDTH{1'b0}}, in_b};
          approx_d = in_approx;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_BUSY: begin
        acc_d = acc_step;
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        // Result register is separate so out_p survives the next accept clearing acc.
        if (cnt_last) begin
          out_p_d      = acc_step;
          out_approx_d = approx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      approx_q     <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_p_q      <= '0;
      out_approx_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      approx_q     <= approx_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_p_q      <= out_p_d;
      out_approx_q <= out_approx_d;
    end
  end

  assign out_p      = out_p_q;
  assign out_approx = out_approx_q;

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(out_p) && $stable(out_approx) && out_valid));

  a_no_accept_when_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != S_IDLE) |-> !in_ready);

endmodule
